// File: rtl/fill_scan_controller.sv
// Scanline fill sequencer: walks rows y_start..y_end, handshaking edge math and row fill per row.
// Optional wait-state watchdog enabled by defining FILL_TIMEOUT_EN.
module fill_scan_controller #(
  parameter int Y_WIDTH        = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fill_en,
  input  logic [Y_WIDTH-1:0] y_start,
  input  logic [Y_WIDTH-1:0] y_end,
  input  logic               abort,
  input  logic               math_done,
  input  logic               fill_done,
  output logic               math_start,
  output logic               row_start,
  output logic               fill_start,
  output logic [Y_WIDTH-1:0] cur_row,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ROW       = 3'd1;
  localparam logic [2:0] S_MATH_WAIT = 3'd2;
  localparam logic [2:0] S_FILL      = 3'd3;
  localparam logic [2:0] S_FILL_WAIT = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]         state;
  logic               fill_en_q;
  logic [Y_WIDTH-1:0] y_end_q;
  logic               start_req;
  logic               wd_expire;

  assign start_req = fill_en & ~fill_en_q;

`ifdef FILL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_count;
  logic             timeout_q;

  // Expiry only counts when the awaited strobe is absent this cycle.
  assign wd_expire = (wd_count == CNT_LAST) &&
                     (((state == S_MATH_WAIT) && !math_done) ||
                      ((state == S_FILL_WAIT) && !fill_done));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_count  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == S_MATH_WAIT) || (state == S_FILL_WAIT))
        wd_count <= wd_count + CNT_W'(1);
      else
        wd_count <= '0;
      timeout_q <= wd_expire && !abort;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      fill_en_q <= 1'b0;
      cur_row   <= '0;
      y_end_q   <= '0;
    end else begin
      fill_en_q <= fill_en;
      // Abort wins over every strobe and the watchdog.
      if ((state != S_IDLE) && abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_req && !abort) begin
              y_end_q <= y_end;
              cur_row <= y_start;
              state   <= (y_start > y_end) ? S_DONE : S_ROW;
            end
          end
          S_ROW:       state <= S_MATH_WAIT;
          S_MATH_WAIT: begin
            if (math_done)      state <= S_FILL;
            else if (wd_expire) state <= S_IDLE;
          end
          S_FILL:      state <= S_FILL_WAIT;
          S_FILL_WAIT: begin
            if (fill_done) begin
              // Equality test avoids wrapping when y_end is the top row.
              if (cur_row == y_end_q) begin
                state <= S_DONE;
              end else begin
                cur_row <= cur_row + Y_WIDTH'(1);
                state   <= S_ROW;
              end
            end else if (wd_expire) begin
              state <= S_IDLE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign math_start = (state == S_ROW);
  assign row_start  = (state == S_ROW);
  assign fill_start = (state == S_FILL);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_fill_scan_controller.sv
// Scoreboard bench for fill_scan_controller: expected pulse sequence is queued at job issue,
// a negedge monitor pops and compares every observed pulse.
module tb_fill_scan_controller;

  localparam int YW    = 10;
  localparam int Y_MAX = (1 << YW) - 1;
  localparam int K_ROW = 1;
  localparam int K_FILL = 2;
  localparam int K_DONE = 3;
  localparam int K_TO   = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          fill_en = 1'b0;
  logic [YW-1:0] y_start = '0;
  logic [YW-1:0] y_end = '0;
  logic          abort = 1'b0;
  logic          math_done = 1'b0;
  logic          fill_done = 1'b0;
  logic          math_start, row_start, fill_start, busy, done, timeout_err;
  logic [YW-1:0] cur_row;

  int total = 0;
  int passed = 0;
  int exp_q[$];
  int md_dly = 2, fd_dly = 3;
  bit math_resp_en = 1'b1, noise_en = 1'b0;

  fill_scan_controller #(.Y_WIDTH(YW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_rst(n_rst), .fill_en(fill_en), .y_start(y_start), .y_end(y_end),
    .abort(abort), .math_done(math_done), .fill_done(fill_done),
    .math_start(math_start), .row_start(row_start), .fill_start(fill_start),
    .cur_row(cur_row), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  function automatic int ev(input int kind, input int row);
    return kind * 65536 + row;
  endfunction

  // Reference: a job is the row list ys..ye, each row a start then a fill, then done.
  function automatic void model_job(input int ys, input int ye);
    if (ys > ye) begin
      exp_q.push_back(ev(K_DONE, ys));
    end else begin
      for (int r = ys; r <= ye; r++) begin
        exp_q.push_back(ev(K_ROW, r));
        exp_q.push_back(ev(K_FILL, r));
      end
      exp_q.push_back(ev(K_DONE, ye));
    end
  endfunction

  task automatic take(input int kind);
    int obs;
    obs = ev(kind, int'(cur_row));
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: got kind %0d row %0d, required no event", kind, cur_row);
    end else begin
      check("event(kind*65536+row)", obs, exp_q.pop_front());
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (math_start || row_start) begin
      check("row_start_with_math_start", row_start, math_start);
      take(K_ROW);
    end
    if (fill_start)  take(K_FILL);
    if (done)        take(K_DONE);
    if (timeout_err) take(K_TO);
  end

  // Edge-math responder; also injects math_done noise while a fill is pending.
  always @(negedge clk) begin
    if (math_start && math_resp_en) begin
      repeat (md_dly) @(posedge clk);
      #1 math_done = 1'b1;
      @(posedge clk);
      #1 math_done = 1'b0;
    end else if (fill_start && noise_en) begin
      @(posedge clk);
      #1 math_done = 1'b1;
      @(posedge clk);
      #1 math_done = 1'b0;
    end
  end

  // Fill responder; also injects fill_done noise during the math wait.
  always @(negedge clk) begin
    if (fill_start) begin
      repeat (fd_dly) @(posedge clk);
      #1 fill_done = 1'b1;
      @(posedge clk);
      #1 fill_done = 1'b0;
    end else if (math_start && noise_en) begin
      @(posedge clk);
      #1 fill_done = 1'b1;
      @(posedge clk);
      #1 fill_done = 1'b0;
    end
  end

  task automatic start_job(input int ys, input int ye);
    @(posedge clk); #1;
    fill_en = 1'b0;
    y_start = YW'(ys);
    y_end   = YW'(ye);
    @(posedge clk); #1;
    fill_en = 1'b1;
  endtask

  // Scrambles the bounds after the start edge to prove they were latched.
  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(posedge clk); #1;
    y_start = YW'($urandom);
    y_end   = YW'($urandom);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_math_start"}, math_start, 1'b0);
    check({tag, "_row_start"}, row_start, 1'b0);
    check({tag, "_fill_start"}, fill_start, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_timeout_err"}, timeout_err, 1'b0);
    check({tag, "_cur_row"}, cur_row, '0);
  endtask

  initial begin
    int ys, ye, n;
    bit found;

    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // Basic 3..5 job with fixed handshake delays.
    md_dly = 2; fd_dly = 3;
    model_job(3, 5);
    start_job(3, 5);
    wait_idle("job_3_5_idle", 200);
    check("job_3_5_final_row", cur_row, 5);

    // fill_en held high: no second job.
    repeat (10) @(negedge clk);
    check("held_fill_en_no_restart", busy, 1'b0);

    // Empty job: done in the second cycle after fill_en is raised.
    model_job(7, 2);
    start_job(7, 2);
    @(negedge clk); check("empty_done_before_edge", done, 1'b0);
    @(negedge clk); check("empty_done_pulse", done, 1'b1);
    @(negedge clk); check("empty_done_cleared", done, 1'b0);
    check("empty_busy_low", busy, 1'b0);

    // Abort coincident with a start edge suppresses the job.
    @(posedge clk); #1 fill_en = 1'b0;
    @(posedge clk); #1 fill_en = 1'b1; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_suppresses_start", busy, 1'b0);

    // Randomized jobs with noise strobes outside their wait states.
    noise_en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      ys = int'($urandom_range(0, 12));
      ye = ys + int'($urandom_range(0, 5)) - 2;
      if (ye < 0) ye = 0;
      md_dly = int'($urandom_range(2, 4));
      fd_dly = int'($urandom_range(2, 4));
      model_job(ys, ye);
      start_job(ys, ye);
      wait_idle("rand_job_idle", 300);
    end

    // Top-of-range rows must terminate without wrapping.
    model_job(Y_MAX - 2, Y_MAX);
    start_job(Y_MAX - 2, Y_MAX);
    wait_idle("top_row_job_idle", 300);
    check("top_row_final", cur_row, Y_MAX);
    noise_en = 1'b0;

    // Abort during the fill wait of row 4.
    md_dly = 2; fd_dly = 6;
    exp_q.push_back(ev(K_ROW, 3));  exp_q.push_back(ev(K_FILL, 3));
    exp_q.push_back(ev(K_ROW, 4));  exp_q.push_back(ev(K_FILL, 4));
    start_job(3, 5);
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (fill_start && cur_row == YW'(4)) found = 1'b1;
    end
    check("abort_reached_row4_fill", found, 1'b1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy_low", busy, 1'b0);
    check("abort_cur_row_held", cur_row, 4);
    repeat (12) @(negedge clk);
    check("abort_late_fill_done_ignored", busy, 1'b0);
    check("abort_cur_row_still_held", cur_row, 4);
    fd_dly = 3;

    // Never-returning math_done.
    math_resp_en = 1'b0;
    exp_q.push_back(ev(K_ROW, 1));
`ifdef FILL_TIMEOUT_EN
    exp_q.push_back(ev(K_TO, 1));
`endif
    start_job(1, 1);
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (math_start) found = 1'b1;
    end
    check("timeout_job_started", found, 1'b1);
`ifdef FILL_TIMEOUT_EN
    repeat (16) @(negedge clk);
    check("timeout_not_early", timeout_err, 1'b0);
    check("timeout_busy_before", busy, 1'b1);
    @(negedge clk);
    check("timeout_pulse", timeout_err, 1'b1);
    check("timeout_busy_after", busy, 1'b0);
    @(negedge clk);
    check("timeout_pulse_single", timeout_err, 1'b0);
    check("timeout_no_done", done, 1'b0);
`else
    repeat (40) @(negedge clk);
    check("no_watchdog_busy_held", busy, 1'b1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("no_watchdog_abort_clears", busy, 1'b0);
`endif

    // Asynchronous reset during the math wait.
    exp_q.push_back(ev(K_ROW, 2));
    start_job(2, 4);
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (math_start) found = 1'b1;
    end
    check("reset_job_started", found, 1'b1);
    @(posedge clk); #1 fill_en = 1'b0;
    @(posedge clk); #2 n_rst = 1'b0;
    #1 check_all_zero("midjob_reset");
    @(negedge clk) n_rst = 1'b1;
    math_resp_en = 1'b1;
    repeat (6) @(negedge clk);
    check("no_restart_after_reset", busy, 1'b0);
    model_job(2, 3);
    start_job(2, 3);
    wait_idle("restart_after_reset_idle", 200);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/fill_scan_controller.md
FILL_SCAN_CONTROLLER -- requirements
Module: fill_scan_controller

Interface
REQ-001 SHALL have parameter Y_WIDTH, default 10, meaning the width of the row index.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the wait-state watchdog limit (used only when FILL_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk  input  1  system clock, all state on the rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fill_en  input  1  fill request; a rising edge starts a job.
REQ-006 SHALL have port y_start  input  Y_WIDTH  first scanline, latched at job start.
REQ-007 SHALL have port y_end  input  Y_WIDTH  last scanline, latched at job start.
REQ-008 SHALL have port abort  input  1  cancels the current job.
REQ-009 SHALL have port math_done  input  1  edge-math unit finished the row.
REQ-010 SHALL have port fill_done  input  1  fill unit finished the row.
REQ-011 SHALL have port math_start  output  1  one-cycle pulse that starts edge math.
REQ-012 SHALL have port row_start  output  1  one-cycle pulse at the start of each row.
REQ-013 SHALL have port fill_start  output  1  one-cycle pulse that starts the row fill.
REQ-014 SHALL have port cur_row  output  Y_WIDTH  current scanline.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on job completion.
REQ-017 SHALL have port timeout_err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-018 SHALL implement the states IDLE, ROW, MATH_WAIT, FILL, FILL_WAIT and DONE.
REQ-019 SHALL register fill_en every cycle; in IDLE, fill_en=1 with previous fill_en=0 latches y_start/y_end, sets cur_row=y_start and moves to ROW, or to DONE when y_start>y_end (empty job, no math_start).
REQ-020 SHALL treat fill_en held high after a job as no new request; a restart requires a new 0->1 edge.
REQ-021 In ROW, SHALL assert row_start and math_start together for one cycle, then go to MATH_WAIT; math_start therefore rises in the cycle after the edge that sampled the fill_en edge.
REQ-022 In MATH_WAIT, SHALL go to FILL when math_done=1; in FILL, SHALL pulse fill_start for one cycle, then go to FILL_WAIT.
REQ-023 In FILL_WAIT, when fill_done=1: if cur_row==y_end, go to DONE; else cur_row<=cur_row+1 and go to ROW.
REQ-024 In DONE, SHALL pulse done for one cycle, then go to IDLE.
REQ-025 SHALL compare cur_row==y_end for equality only; y_end=2^Y_WIDTH-1 SHALL terminate without cur_row wrapping.
REQ-026 SHALL sample math_done and fill_done only in their own wait state and ignore them in all other states, including a strobe coincident with math_start or fill_start.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done or timeout_err pulse; abort has priority over math_done, fill_done and the watchdog.
REQ-028 abort in IDLE SHALL be ignored; abort coincident with a valid fill_en edge SHALL suppress the start.
REQ-029 cur_row SHALL hold its value in IDLE after a job or an abort.

Reset
REQ-030 n_rst=0 SHALL asynchronously force: state IDLE, cur_row=0, latched bounds=0, registered fill_en=0, watchdog count=0, and all outputs 0.
REQ-031 Reset mid-job SHALL abandon the job with no done pulse; after release, a new fill_en edge is required to start.

Configuration
REQ-032 With macro FILL_TIMEOUT_EN defined, SHALL count cycles in MATH_WAIT and FILL_WAIT, clearing the count on each wait-state entry. If the count reaches TIMEOUT_CYCLES without the awaited strobe, timeout_err SHALL pulse for one cycle and the state SHALL go to IDLE with no done pulse.
REQ-033 Without FILL_TIMEOUT_EN, SHALL omit the watchdog logic, tie timeout_err to 0, and wait indefinitely.

Verification
REQ-034 The bench SHALL drive y_start=3, y_end=5, with math_done 2 cycles after math_start and fill_done 3 cycles after fill_start; the block SHALL produce 3 math_start, 3 row_start and 3 fill_start pulses with cur_row 3,4,5, then exactly 1 done pulse, and busy low afterwards.
REQ-035 The bench SHALL drive y_start=7, y_end=2 with a fill_en edge; done SHALL pulse once, 2 cycles after the fill_en edge is registered, with no math_start and no fill_start.
REQ-036 The bench SHALL keep fill_en high after done; no second job SHALL start. Then fill_en 0->1 SHALL start a new job.
REQ-037 The bench SHALL assert abort for 1 cycle during FILL_WAIT of row 4 (job 3..5); the block SHALL enter IDLE, busy=0, with no done pulse, cur_row=4 held, and a later fill_done ignored.
REQ-038 The bench SHALL build with FILL_TIMEOUT_EN and TIMEOUT_CYCLES=16 and never return math_done; timeout_err SHALL pulse once 16 cycles after MATH_WAIT entry, then IDLE, with no done pulse. Without the macro, busy SHALL stay high.
REQ-039 The bench SHALL assert n_rst=0 asynchronously mid-MATH_WAIT; all outputs SHALL be 0 immediately, and a restart SHALL occur only on a fresh fill_en edge.
